pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//  Program counter with a programmable branch-target table. Replaces the fixed,
//  hard-coded relative-target lookup: entries are loadable at run time, depth and
//  width are parameterised, and each entry is tagged relative or absolute.
//  Sits in the fetch stage and drives the instruction memory address every cycle.
//  Also keeps a saturating count of taken branches for performance debug.
// PARAMETERS
//  D   12  PC / target width in bits; all PC arithmetic is modulo 2**D
//  IW  3   table index width; table depth = 2**IW entries
//  CW  16  taken-branch counter width
// PORTS
//  Clk         in   1   single clock, all state updates on posedge
//  Reset       in   1   synchronous, active-high; overrides every other input
//  wr_en       in   1   write one table entry this cycle
//  wr_idx      in   IW  entry to write
//  wr_target   in   D   target value: two's-complement offset or absolute PC
//  wr_abs      in   1   1 = entry is absolute, 0 = entry is PC-relative
//  branch_en   in   1   current instruction is a branch
//  taken       in   1   branch condition true; ignored unless branch_en=1
//  how_high    in   IW  table index used by the branch
//  halt        in   1   stop fetching; PC freezes
//  pc          out  D   current program counter (registered)
//  done        out  1   sticky halt indication (registered)
//  branch_cnt  out  CW  number of taken branches, saturating (registered)
// BEHAVIOUR
//  - Reset (sampled at posedge): pc=0, done=0, branch_cnt=0, every entry
//    target=0 and abs=0. Writes, branches and halt in a reset cycle are dropped.
//  - Next-PC priority, evaluated each posedge with Reset=0:
//    1. done=1 or halt=1: pc holds. done becomes 1 at the same edge halt is
//       first seen and stays 1 until Reset.
//    2. branch_en=1 & taken=1: if abs[how_high], pc <= target[how_high];
//       otherwise pc <= (pc + target[how_high]) mod 2**D, target read as signed.
//    3. Otherwise pc <= (pc + 1) mod 2**D. 2**D-1 wraps to 0.
//  - A relative entry of 0 holds the PC (spin loop). This is legal and is not
//    treated as a halt.
//  - Latency: one cycle. The branch decision presented in cycle n sets pc in
//    cycle n+1. No bubbles, no internal pipelining.
//  - Table write:
//    - Takes effect at the posedge, and wr_en is honoured even while done=1.
//    - Read-before-write: a branch to the index being written in the same
//      cycle uses the OLD entry. The new value is visible from the next cycle.
//  - branch_cnt:
//    - Increments on each accepted taken branch, i.e. only when rule 2 is applied.
//    - Saturates at 2**CW-1 and never wraps.
//    - Not incremented while halted.
//  - The table is a flop array (2**IW x (D+1)) with a combinational read on
//    how_high. No X may reach pc for any index after reset.
//  - Reset in mid-program: the next cycle pc=0. Table contents are lost and must
//    be reloaded by software.
// TESTING
//  1. Reset, then 5 idle cycles -> pc = 0,1,2,3,4,5; done=0; branch_cnt=0.
//  2. Write idx3 = -41 (relative). At pc=100, branch_en=1, taken=1, how_high=3
//     -> next pc=59, branch_cnt=1. Same with taken=0 -> pc=101, count unchanged.
//  3. Write idx5 = 398 with abs=1. Branch idx5 from pc=7 -> pc=398. Then at
//     pc=4090 branch relative +10 (D=12) -> pc=4 (wrap). At pc=4095 with no
//     branch -> pc=0.
//  4. Same cycle: write idx2 = 50 (old value 15, relative) and branch idx2 from
//     pc=20 -> pc=35. Repeat the branch from pc=35 -> pc=85.
//  5. Assert halt at pc=12 with a taken branch pending -> pc stays 12 and done=1
//     next cycle. Deassert halt -> pc still 12 and done stays 1. Reset -> pc=0,
//     done=0.
//  6. CW=2: 5 taken branches -> branch_cnt sequence 1,2,3,3,3. Reset asserted
//     together with wr_en -> the entry reads 0 afterwards.

Source files
------------

// File: rtl/pc_branch_if.sv
// Fetch-stage control bundle for pc_branch_unit: table-write port, branch request,
// halt, and the registered PC / done / taken-branch count returned by the unit.
interface pc_branch_if #(
    parameter int D  = 12,
    parameter int IW = 3,
    parameter int CW = 16
);
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [D-1:0]  wr_target;
    logic          wr_abs;
    logic          branch_en;
    logic          taken;
    logic [IW-1:0] how_high;
    logic          halt;
    logic [D-1:0]  pc;
    logic          done;
    logic [CW-1:0] branch_cnt;

    modport master (
        output wr_en, wr_idx, wr_target, wr_abs, branch_en, taken, how_high, halt,
        input  pc, done, branch_cnt
    );

    modport slave (
        input  wr_en, wr_idx, wr_target, wr_abs, branch_en, taken, how_high, halt,
        output pc, done, branch_cnt
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter with a run-time loadable branch-target table (relative or absolute
// entries), sticky halt, and a saturating taken-branch counter.
module pc_branch_unit #(
    parameter int D  = 12,
    parameter int IW = 3,
    parameter int CW = 16
) (
    input logic        Clk,
    input logic        Reset,
    pc_branch_if.slave bus
);
    localparam int DEPTH = 2 ** IW;

    logic [D-1:0]     tgt_q [DEPTH];
    logic [DEPTH-1:0] abs_q;
    logic [D-1:0]     pc_q, pc_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             take;
    logic [D-1:0]     rd_tgt;
    logic             rd_abs;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Combinational table read happens before this edge's write lands.
    assign rd_tgt = tgt_q[bus.how_high];
    assign rd_abs = abs_q[bus.how_high];
    assign take   = bus.branch_en & bus.taken & ~bus.halt & ~done_q;

    always_comb begin
        pc_d   = pc_q + 1'b1;
        done_d = done_q | bus.halt;
        cnt_d  = cnt_q;
        if (done_q || bus.halt) begin
            pc_d = pc_q;
        end else if (take) begin
            // Modulo-2**D add gives the signed-offset result directly.
            pc_d  = rd_abs ? rd_tgt : pc_q + rd_tgt;
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q   <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            abs_q  <= '0;
            for (int i = 0; i < DEPTH; i++) tgt_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            if (bus.wr_en) begin
                tgt_q[bus.wr_idx] <= bus.wr_target;
                abs_q[bus.wr_idx] <= bus.wr_abs;
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.done       = done_q;
    assign bus.branch_cnt = cnt_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: main instance with defaults plus a CW=2
// instance for counter saturation.
module tb_pc_branch_unit;
    logic clk;
    logic rst;
    logic rst2;
    int   n_tests;
    int   n_fail;

    pc_branch_if #(.D(12), .IW(3), .CW(16)) bus ();
    pc_branch_if #(.D(12), .IW(3), .CW(2))  bus2 ();

    pc_branch_unit #(.D(12), .IW(3), .CW(16)) dut (.Clk(clk), .Reset(rst), .bus(bus));
    pc_branch_unit #(.D(12), .IW(3), .CW(2))  dut2 (.Clk(clk), .Reset(rst2), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the main instance, then return inputs to idle.
    task automatic cyc(input logic wr, input logic [2:0] widx, input logic [11:0] wtgt,
                       input logic wabs, input logic be, input logic tk,
                       input logic [2:0] hh, input logic hlt);
        bus.wr_en = wr; bus.wr_idx = widx; bus.wr_target = wtgt; bus.wr_abs = wabs;
        bus.branch_en = be; bus.taken = tk; bus.how_high = hh; bus.halt = hlt;
        tick();
        bus.wr_en = 0; bus.branch_en = 0; bus.taken = 0; bus.halt = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick();
        rst = 0;
        n_tests++;
        if (bus.pc !== 12'd0 || bus.done !== 1'b0 || bus.branch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: pc=%0d done=%0b cnt=%0d, expected 0 0 0", bus.pc, bus.done, bus.branch_cnt);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_tests++;
            if (bus.pc !== 12'(i) || bus.done !== 1'b0 || bus.branch_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL idle_inc: pc=%0d done=%0b cnt=%0d, expected %0d 0 0", bus.pc, bus.done, bus.branch_cnt, i);
            end
        end
    endtask

    task automatic test_relative;
        cyc(1, 3'd0, 12'd100, 1, 0, 0, 3'd0, 0);   // pc 6
        cyc(1, 3'd3, 12'd4055, 0, 1, 1, 3'd0, 0);  // idx3 = -41; pc 100, cnt 1
        n_tests++;
        if (bus.pc !== 12'd100) begin
            n_fail++;
            $display("FAIL abs_to_100: pc=%0d, expected 100", bus.pc);
        end
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd3, 0);
        n_tests++;
        if (bus.pc !== 12'd59 || bus.branch_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL rel_neg: pc=%0d cnt=%0d, expected 59 2", bus.pc, bus.branch_cnt);
        end
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd0, 0);     // pc 100, cnt 3
        cyc(0, 3'd0, 12'd0, 0, 1, 0, 3'd3, 0);
        n_tests++;
        if (bus.pc !== 12'd101 || bus.branch_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL not_taken: pc=%0d cnt=%0d, expected 101 3", bus.pc, bus.branch_cnt);
        end
    endtask

    task automatic test_absolute_wrap;
        cyc(1, 3'd5, 12'd398, 1, 0, 0, 3'd0, 0);   // pc 102
        cyc(1, 3'd1, 12'd7, 1, 0, 0, 3'd0, 0);     // pc 103
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd1, 0);     // pc 7, cnt 4
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd5, 0);
        n_tests++;
        if (bus.pc !== 12'd398 || bus.branch_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL abs_398: pc=%0d cnt=%0d, expected 398 5", bus.pc, bus.branch_cnt);
        end
        cyc(1, 3'd6, 12'd4090, 1, 0, 0, 3'd0, 0);  // pc 399
        cyc(1, 3'd7, 12'd10, 0, 0, 0, 3'd0, 0);    // pc 400
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd6, 0);     // pc 4090, cnt 6
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd7, 0);
        n_tests++;
        if (bus.pc !== 12'd4 || bus.branch_cnt !== 16'd7) begin
            n_fail++;
            $display("FAIL rel_wrap: pc=%0d cnt=%0d, expected 4 7", bus.pc, bus.branch_cnt);
        end
        cyc(1, 3'd6, 12'd4095, 1, 0, 0, 3'd0, 0);  // pc 5
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd6, 0);
        n_tests++;
        if (bus.pc !== 12'd4095) begin
            n_fail++;
            $display("FAIL abs_4095: pc=%0d, expected 4095", bus.pc);
        end
        cyc(0, 3'd0, 12'd0, 0, 0, 0, 3'd0, 0);
        n_tests++;
        if (bus.pc !== 12'd0 || bus.branch_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL inc_wrap: pc=%0d cnt=%0d, expected 0 8", bus.pc, bus.branch_cnt);
        end
    endtask

    task automatic test_read_before_write;
        cyc(1, 3'd2, 12'd15, 0, 0, 0, 3'd0, 0);    // pc 1
        cyc(1, 3'd1, 12'd20, 1, 0, 0, 3'd0, 0);    // pc 2
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd1, 0);     // pc 20, cnt 9
        cyc(1, 3'd2, 12'd50, 0, 1, 1, 3'd2, 0);
        n_tests++;
        if (bus.pc !== 12'd35 || bus.branch_cnt !== 16'd10) begin
            n_fail++;
            $display("FAIL rbw_old: pc=%0d cnt=%0d, expected 35 10", bus.pc, bus.branch_cnt);
        end
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd2, 0);
        n_tests++;
        if (bus.pc !== 12'd85 || bus.branch_cnt !== 16'd11) begin
            n_fail++;
            $display("FAIL rbw_new: pc=%0d cnt=%0d, expected 85 11", bus.pc, bus.branch_cnt);
        end
    endtask

    task automatic test_halt;
        cyc(1, 3'd1, 12'd12, 1, 0, 0, 3'd0, 0);    // pc 86
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd1, 0);     // pc 12, cnt 12
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd2, 1);
        n_tests++;
        if (bus.pc !== 12'd12 || bus.done !== 1'b1 || bus.branch_cnt !== 16'd12) begin
            n_fail++;
            $display("FAIL halt: pc=%0d done=%0b cnt=%0d, expected 12 1 12", bus.pc, bus.done, bus.branch_cnt);
        end
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd2, 0);
        n_tests++;
        if (bus.pc !== 12'd12 || bus.done !== 1'b1 || bus.branch_cnt !== 16'd12) begin
            n_fail++;
            $display("FAIL sticky_done: pc=%0d done=%0b cnt=%0d, expected 12 1 12", bus.pc, bus.done, bus.branch_cnt);
        end
        rst = 1;
        tick();
        rst = 0;
        n_tests++;
        if (bus.pc !== 12'd0 || bus.done !== 1'b0 || bus.branch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL halt_reset: pc=%0d done=%0b cnt=%0d, expected 0 0 0", bus.pc, bus.done, bus.branch_cnt);
        end
        // Cleared table: idx2 is now relative 0, a legal spin loop.
        cyc(0, 3'd0, 12'd0, 0, 1, 1, 3'd2, 0);
        n_tests++;
        if (bus.pc !== 12'd0 || bus.done !== 1'b0 || bus.branch_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL spin: pc=%0d done=%0b cnt=%0d, expected 0 0 1", bus.pc, bus.done, bus.branch_cnt);
        end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus2.wr_en = 1; bus2.wr_idx = 3'd0; bus2.wr_target = 12'd1; bus2.wr_abs = 0;
        tick();
        bus2.wr_en = 0;                             // pc2 = 1
        bus2.branch_en = 1; bus2.taken = 1; bus2.how_high = 3'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (bus2.branch_cnt !== exp_cnt[i] || bus2.pc !== 12'(i + 2)) begin
                n_fail++;
                $display("FAIL sat_cnt[%0d]: cnt=%0d pc=%0d, expected %0d %0d", i, bus2.branch_cnt, bus2.pc, exp_cnt[i], i + 2);
            end
        end
        bus2.branch_en = 0; bus2.taken = 0;
        rst2 = 1;
        bus2.wr_en = 1; bus2.wr_idx = 3'd0; bus2.wr_target = 12'd100; bus2.wr_abs = 1;
        tick();
        rst2 = 0;
        bus2.wr_en = 0;
        bus2.branch_en = 1; bus2.taken = 1; bus2.how_high = 3'd0;
        tick();
        bus2.branch_en = 0; bus2.taken = 0;
        n_tests++;
        if (bus2.pc !== 12'd0 || bus2.branch_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_drops_write: pc=%0d cnt=%0d, expected 0 1", bus2.pc, bus2.branch_cnt);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1; rst2 = 1;
        bus.wr_en = 0; bus.wr_idx = 0; bus.wr_target = 0; bus.wr_abs = 0;
        bus.branch_en = 0; bus.taken = 0; bus.how_high = 0; bus.halt = 0;
        bus2.wr_en = 0; bus2.wr_idx = 0; bus2.wr_target = 0; bus2.wr_abs = 0;
        bus2.branch_en = 0; bus2.taken = 0; bus2.how_high = 0; bus2.halt = 0;
        tick();
        rst2 = 0;
        test_reset();
        test_relative();
        test_absolute_wrap();
        test_read_before_write();
        test_halt();
        rst2 = 1;
        tick();
        rst2 = 0;
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
